// File: rtl/zap_uop_pkg.sv
// Shared types for the decode micro-op sequencer: state encoding,
// extended register numbers and micro-op builders.
package zap_uop_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BACKUP,
    S_MEMOP,
    S_WB_BASE,
    S_WRITE_PC,
    S_SWP_ST,
    S_SWP_MOV
  } state_t;

  // Extended register space: bit 4 of each register number lives
  // above the 32-bit word (Rn->32, Rd->33, Rm->34).
  localparam int RN_X = 32;
  localparam int RD_X = 33;
  localparam int RM_X = 34;

  localparam logic [4:0] ARCH_PC      = 5'd15;
  localparam logic [4:0] ARCH_USR2_R8 = 5'd16;
  localparam logic [4:0] ARCH_DUMMY0  = 5'd23;
  localparam logic [4:0] ARCH_DUMMY1  = 5'd24;

  localparam logic [34:0] UOP_NOP = '0;

  function automatic logic [34:0] uop_mov(
    input logic [3:0] c,
    input logic       s,
    input logic [4:0] rd,
    input logic [4:0] rm
  );
    return {rm[4], rd[4], 1'b0, c, 3'b000, 4'b1101, s,
            4'h0, rd[3:0], 8'h00, rm[3:0]};
  endfunction

  // Pre-indexed immediate LDR/STR, no writeback.
  function automatic logic [34:0] uop_ldst(
    input logic [3:0]  c,
    input logic        l,
    input logic        b,
    input logic        u,
    input logic [4:0]  rn,
    input logic [4:0]  rd,
    input logic [11:0] imm
  );
    return {1'b0, rd[4], rn[4], c, 2'b01, 1'b0, 1'b1, u, b,
            1'b0, l, rn[3:0], rd[3:0], imm};
  endfunction

  // ADD/SUB rd, rn, #imm8 with zero rotation.
  function automatic logic [34:0] uop_alu(
    input logic [3:0] c,
    input logic       add,
    input logic [4:0] rd,
    input logic [4:0] rn,
    input logic [7:0] imm
  );
    return {1'b0, rd[4], rn[4], c, 3'b001,
            (add ? 4'b0100 : 4'b0010), 1'b0,
            rn[3:0], rd[3:0], 4'h0, imm};
  endfunction

endpackage

// File: rtl/zap_uop_prienc.sv
// Lowest-set-bit encoder and popcount over a register list.
// Ports: i_vec list in; o_idx lowest set bit; o_cnt ones count.
module zap_uop_prienc #(
  parameter int NUM_REGS = 16,
  parameter int CNT_W    = 5,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic [NUM_REGS-1:0] i_vec,
  output logic [IDX_W-1:0]    o_idx,
  output logic [CNT_W-1:0]    o_cnt
);

  always_comb begin
    o_idx = '0;
    o_cnt = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx = IDX_W'(i);
      o_cnt = o_cnt + CNT_W'(i_vec[i]);
    end
  end

endmodule

// File: rtl/zap_decode_uop_sequencer.sv
// Cracks LDM/STM and SWP/SWPB into single-transfer micro-ops.
// Ports: fetch in (i_instruction/valid/irq/fiq), flush+hold in,
// micro-op out (o_instruction/valid/irq/fiq), o_stall_from_decode,
// o_busy and o_remaining (registered status).
module zap_decode_uop_sequencer
  import zap_uop_pkg::*;
#(
  parameter int NUM_REGS   = 16,
  parameter int STEP_BYTES = 4,
  parameter int OUT_W      = 35,
  parameter int CNT_W      = 5
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [31:0]      i_instruction,
  input  logic             i_instruction_valid,
  input  logic             i_irq,
  input  logic             i_fiq,
  input  logic             i_clear_from_writeback,
  input  logic             i_data_stall,
  input  logic             i_clear_from_alu,
  input  logic             i_stall_from_shifter,
  input  logic             i_issue_stall,
  output logic [OUT_W-1:0] o_instruction,
  output logic             o_instruction_valid,
  output logic             o_stall_from_decode,
  output logic             o_irq,
  output logic             o_fiq,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_remaining
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int OFF_W = 10;

  state_t              r_state, w_state_nxt, w_exit;
  logic [NUM_REGS-1:0] r_reglist, w_reglist_nxt;
  logic [NUM_REGS-1:0] w_list, w_enc_vec;
  logic [CNT_W-1:0]    r_remaining, w_rem_nxt, w_cnt;
  logic [OFF_W-1:0]    r_offset, w_off_nxt;
  logic [OFF_W-1:0]    w_nstep, w_start, w_abs;
  logic [IDX_W-1:0]    w_idx;
  logic [34:0]         w_uop;
  logic [15:0]         w_list16;
  logic [3:0]          w_cond;
  logic [4:0]          w_rn, w_rd, w_rm, w_rk, w_rk_map;
  logic                w_p, w_u, w_s, w_w, w_l;
  logic                w_is_blk, w_is_swp, w_pc_load;
  logic                w_rn_in_list, w_usr_map;
  logic                w_clr, w_adv;

  assign w_cond   = i_instruction[31:28];
  assign w_p      = i_instruction[24];
  assign w_u      = i_instruction[23];
  assign w_s      = i_instruction[22];
  assign w_w      = i_instruction[21];
  assign w_l      = i_instruction[20];
  assign w_rn     = {1'b0, i_instruction[19:16]};
  assign w_rd     = {1'b0, i_instruction[15:12]};
  assign w_rm     = {1'b0, i_instruction[3:0]};
  assign w_list16 = i_instruction[15:0];
  assign w_list   = i_instruction[NUM_REGS-1:0];

  assign w_is_blk = i_instruction[27:25] == 3'b100;
  assign w_is_swp = i_instruction[27:23] == 5'b00010 &&
                    i_instruction[21:20] == 2'b00 &&
                    i_instruction[11:4] == 8'h09;

  assign w_pc_load    = w_l & w_list16[15];
  assign w_rn_in_list = w_l & w_list16[w_rn[3:0]];
  assign w_usr_map    = w_s & ~w_pc_load;

  // Outside MEMOP the encoder counts the held instruction's list,
  // which stays stable for the whole sequence.
  assign w_enc_vec = (r_state == S_MEMOP) ? r_reglist : w_list;

  zap_uop_prienc #(
    .NUM_REGS (NUM_REGS),
    .CNT_W    (CNT_W)
  ) u_prienc (
    .i_vec (w_enc_vec),
    .o_idx (w_idx),
    .o_cnt (w_cnt)
  );

  assign w_nstep = OFF_W'(w_cnt) * OFF_W'(STEP_BYTES);

  always_comb begin
    unique case ({w_p, w_u})
      2'b01:   w_start = '0;
      2'b11:   w_start = OFF_W'(STEP_BYTES);
      2'b00:   w_start = OFF_W'(STEP_BYTES) - w_nstep;
      default: w_start = '0 - w_nstep;
    endcase
  end

  assign w_abs = r_offset[OFF_W-1] ? (~r_offset + OFF_W'(1))
                                   : r_offset;

  assign w_rk = 5'(w_idx);

  always_comb begin
    w_rk_map = w_rk;
    if (w_l && w_rk == ARCH_PC)
      w_rk_map = ARCH_DUMMY1;
    else if (w_usr_map && w_rk >= 5'd8 && w_rk <= 5'd14)
      w_rk_map = ARCH_USR2_R8 + (w_rk - 5'd8);
  end

  always_comb begin
    if (w_w)            w_exit = S_WB_BASE;
    else if (w_pc_load) w_exit = S_WRITE_PC;
    else                w_exit = S_IDLE;
  end

  always_comb begin
    w_state_nxt         = r_state;
    w_reglist_nxt       = r_reglist;
    w_rem_nxt           = r_remaining;
    w_off_nxt           = r_offset;
    w_uop               = {3'b000, i_instruction};
    o_instruction_valid = i_instruction_valid;
    o_stall_from_decode = 1'b0;
    o_irq               = 1'b0;
    o_fiq               = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        o_irq = i_irq;
        o_fiq = i_fiq;
        if (i_instruction_valid && w_is_blk) begin
          w_uop = uop_mov(w_cond, 1'b0, ARCH_DUMMY0, w_rn);
          o_stall_from_decode = 1'b1;
          w_reglist_nxt = w_list;
          w_rem_nxt     = w_cnt;
          w_off_nxt     = w_start;
          w_state_nxt   = S_MEMOP;
        end else if (i_instruction_valid && w_is_swp) begin
          w_uop = uop_ldst(w_cond, 1'b1, w_s, 1'b1, w_rn,
                           ARCH_DUMMY1, 12'h000);
          o_stall_from_decode = 1'b1;
          w_state_nxt = S_SWP_ST;
        end
      end
      S_MEMOP: begin
        o_instruction_valid = 1'b1;
        if (r_remaining == '0) begin
          w_uop = UOP_NOP;
          w_state_nxt = w_exit;
          o_stall_from_decode = (w_exit != S_IDLE);
        end else begin
          w_uop = uop_ldst(w_cond, w_l, 1'b0,
                           ~r_offset[OFF_W-1], ARCH_DUMMY0,
                           w_rk_map,
                           {{(12-OFF_W){1'b0}}, w_abs});
          w_reglist_nxt = r_reglist & (r_reglist - NUM_REGS'(1));
          w_off_nxt = r_offset + OFF_W'(STEP_BYTES);
          w_rem_nxt = r_remaining - CNT_W'(1);
          if (r_remaining == CNT_W'(1)) begin
            w_state_nxt = w_exit;
            o_stall_from_decode = (w_exit != S_IDLE);
          end else begin
            o_stall_from_decode = 1'b1;
          end
        end
      end
      S_WB_BASE: begin
        o_instruction_valid = 1'b1;
        // A loaded base must win over the computed writeback.
        w_uop = w_rn_in_list ? UOP_NOP
              : uop_alu(w_cond, w_u, w_rn, ARCH_DUMMY0,
                        w_nstep[7:0]);
        o_stall_from_decode = w_pc_load;
        w_state_nxt = w_pc_load ? S_WRITE_PC : S_IDLE;
      end
      S_WRITE_PC: begin
        o_instruction_valid = 1'b1;
        w_uop = uop_mov(w_cond, w_s, ARCH_PC, ARCH_DUMMY1);
        w_state_nxt = S_IDLE;
      end
      S_SWP_ST: begin
        o_instruction_valid = 1'b1;
        w_uop = uop_ldst(w_cond, 1'b0, w_s, 1'b1, w_rn, w_rm,
                         12'h000);
        o_stall_from_decode = 1'b1;
        w_state_nxt = S_SWP_MOV;
      end
      S_SWP_MOV: begin
        o_instruction_valid = 1'b1;
        w_uop = uop_mov(w_cond, 1'b0, w_rd, ARCH_DUMMY1);
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_instruction = OUT_W'(w_uop);
  assign o_busy        = (r_state != S_IDLE);
  assign o_remaining   = r_remaining;

  assign w_clr = i_reset | i_clear_from_writeback |
                 (~i_data_stall & i_clear_from_alu);
  assign w_adv = ~i_data_stall & ~i_clear_from_alu &
                 ~i_stall_from_shifter & ~i_issue_stall;

  always_ff @(posedge i_clk) begin
    if (w_clr) begin
      r_state     <= S_IDLE;
      r_reglist   <= '0;
      r_remaining <= '0;
      r_offset    <= '0;
    end else if (w_adv) begin
      r_state     <= w_state_nxt;
      r_reglist   <= w_reglist_nxt;
      r_remaining <= w_rem_nxt;
      r_offset    <= w_off_nxt;
    end
  end

endmodule

// File: tb/tb_zap_decode_uop_sequencer.sv
// Self-checking bench for zap_decode_uop_sequencer.
// Expected micro-op streams come from an instruction-level model.
module tb_zap_decode_uop_sequencer;

  localparam int D0 = 23;
  localparam int D1 = 24;
  localparam int U8 = 16;
  localparam logic [31:0] ADD_I = 32'hE2811001;

  logic        clk = 1'b0;
  logic        i_reset, i_instruction_valid, i_irq, i_fiq;
  logic        i_clear_from_writeback, i_data_stall;
  logic        i_clear_from_alu, i_stall_from_shifter;
  logic        i_issue_stall;
  logic [31:0] i_instruction;
  logic [34:0] o_instruction;
  logic        o_instruction_valid, o_stall_from_decode;
  logic        o_irq, o_fiq, o_busy;
  logic [4:0]  o_remaining;

  always #5 clk = ~clk;

  zap_decode_uop_sequencer dut (
    .i_clk                  (clk),
    .i_reset                (i_reset),
    .i_instruction          (i_instruction),
    .i_instruction_valid    (i_instruction_valid),
    .i_irq                  (i_irq),
    .i_fiq                  (i_fiq),
    .i_clear_from_writeback (i_clear_from_writeback),
    .i_data_stall           (i_data_stall),
    .i_clear_from_alu       (i_clear_from_alu),
    .i_stall_from_shifter   (i_stall_from_shifter),
    .i_issue_stall          (i_issue_stall),
    .o_instruction          (o_instruction),
    .o_instruction_valid    (o_instruction_valid),
    .o_stall_from_decode    (o_stall_from_decode),
    .o_irq                  (o_irq),
    .o_fiq                  (o_fiq),
    .o_busy                 (o_busy),
    .o_remaining            (o_remaining)
  );

  typedef struct packed {
    logic [34:0] u;
    logic        v;
    logic        st;
    logic        iq;
    logic        fq;
    logic        bz;
    logic [4:0]  rem;
  } exp_t;

  logic [44:0] w_obs;
  assign w_obs = {o_instruction, o_instruction_valid,
                  o_stall_from_decode, o_irq, o_fiq,
                  o_busy, o_remaining};

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [34:0] e_mov(logic [3:0] c,
    logic s, int rd, int rm);
    logic [31:0] w;
    w = {c, 3'b000, 4'b1101, s, 4'h0, rd[3:0], 8'h00, rm[3:0]};
    return {(rm >= 16), (rd >= 16), 1'b0, w};
  endfunction

  function automatic logic [34:0] e_ldst(logic [3:0] c,
    logic l, logic b, int off, int rn, int rd);
    logic [31:0] w;
    int mag;
    mag = (off < 0) ? -off : off;
    w = {c, 2'b01, 1'b0, 1'b1, (off >= 0), b, 1'b0, l,
         rn[3:0], rd[3:0], mag[11:0]};
    return {1'b0, (rd >= 16), (rn >= 16), w};
  endfunction

  function automatic logic [34:0] e_alu(logic [3:0] c,
    logic add, int rd, int rn, int imm);
    logic [31:0] w;
    w = {c, 3'b001, (add ? 4'b0100 : 4'b0010), 1'b0,
         rn[3:0], rd[3:0], 4'h0, imm[7:0]};
    return {1'b0, (rd >= 16), (rn >= 16), w};
  endfunction

  function automatic exp_t mk(logic [34:0] u, logic st,
    logic iq, logic fq, logic bz, int rem);
    return {u, 1'b1, st, iq, fq, bz, rem[4:0]};
  endfunction

  // Instruction-level model: list of cycles the sequencer must emit.
  task automatic build_model(input logic [31:0] ins,
    input logic iq, input logic fq);
    logic [3:0]  c;
    logic [15:0] lst;
    logic        p, u, s, w, l, pcl;
    int          rn, n, r, off, rd, rm;
    int          regs[$];
    exp_q.delete();
    c   = ins[31:28];
    lst = ins[15:0];
    if (ins[27:25] == 3'b100) begin
      {p, u, s, w, l} = ins[24:20];
      rn = int'(ins[19:16]);
      for (int i = 0; i < 16; i++)
        if (lst[i[3:0]]) regs.push_back(i);
      n = regs.size();
      pcl = l && lst[15];
      exp_q.push_back(mk(e_mov(c, 1'b0, D0, rn), 1, iq, fq, 0, 0));
      if (n == 0) exp_q.push_back(mk('0, w || pcl, 0, 0, 1, 0));
      for (int i = 0; i < n; i++) begin
        r = regs[i];
        if (p) off = u ? (i + 1) * 4 : (i - n) * 4;
        else   off = u ? i * 4 : (i - n + 1) * 4;
        rd = r;
        if (l && r == 15) rd = D1;
        else if (s && !pcl && r >= 8 && r <= 14) rd = U8 + r - 8;
        exp_q.push_back(mk(e_ldst(c, l, 1'b0, off, D0, rd),
                           (i < n - 1) || w || pcl, 0, 0, 1, n - i));
      end
      if (w)
        exp_q.push_back(mk((l && lst[rn[3:0]]) ? 35'd0
                           : e_alu(c, u, rn, D0, n * 4),
                           pcl, 0, 0, 1, 0));
      if (pcl) exp_q.push_back(mk(e_mov(c, s, 15, D1), 0, 0, 0, 1, 0));
    end else if (ins[27:23] == 5'b00010 && ins[21:20] == 2'b00 &&
                 ins[11:4] == 8'h09) begin
      rn = int'(ins[19:16]);
      rd = int'(ins[15:12]);
      rm = int'(ins[3:0]);
      exp_q.push_back(mk(e_ldst(c, 1'b1, ins[22], 0, rn, D1),
                         1, iq, fq, 0, 0));
      exp_q.push_back(mk(e_ldst(c, 1'b0, ins[22], 0, rn, rm),
                         1, 0, 0, 1, 0));
      exp_q.push_back(mk(e_mov(c, 1'b0, rd, D1), 0, 0, 0, 1, 0));
    end else begin
      exp_q.push_back(mk({3'b000, ins}, 0, iq, fq, 0, 0));
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    i_instruction = ADD_I;
    i_instruction_valid = 1'b1;
    build_model(ADD_I, 1'b1, 1'b0);
    i_irq = 1'b1;
    @(negedge clk);
    n_tests++;
    if (w_obs !== exp_q[0])
      $display("FAIL reset_pass: got %h want %h", w_obs, exp_q[0]);
    if (w_obs !== exp_q[0]) n_fail++;
    i_irq = 1'b0;
    @(posedge clk); #1;
    i_reset = 1'b0;
    i_instruction = 32'hE8B0000E;
    @(posedge clk); #1;
    @(posedge clk); #1;
    i_reset = 1'b1;
    @(negedge clk);
    n_tests++;
    if (o_busy !== 1'b1 || o_remaining !== 5'd2) begin
      n_fail++;
      $display("FAIL mid_seq: busy %b rem %0d want 1 2",
               o_busy, o_remaining);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++;
    if (o_busy !== 1'b0 || o_remaining !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_abort: busy %b rem %0d want 0 0",
               o_busy, o_remaining);
    end
    @(posedge clk); #1;
    i_reset = 1'b0;
  endtask

  task automatic test_ldm_pc();
    build_model(32'hE8B08006, 1'b1, 1'b1);
    i_instruction = 32'hE8B08006;
    i_irq = 1'b1;
    i_fiq = 1'b1;
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      n_tests++;
      if (w_obs !== exp_q[k]) begin
        n_fail++;
        $display("FAIL ldm_pc step %0d: got %h want %h",
                 k, w_obs, exp_q[k]);
      end
      @(posedge clk); #1;
    end
    i_irq = 1'b0;
    i_fiq = 1'b0;
  endtask

  task automatic test_stmdb();
    build_model(32'hE92D00F0, 1'b0, 1'b0);
    i_instruction = 32'hE92D00F0;
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      n_tests++;
      if (w_obs !== exp_q[k]) begin
        n_fail++;
        $display("FAIL stmdb step %0d: got %h want %h",
                 k, w_obs, exp_q[k]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stm_user();
    build_model(32'hE8C00300, 1'b0, 1'b0);
    i_instruction = 32'hE8C00300;
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      n_tests++;
      if (w_obs !== exp_q[k]) begin
        n_fail++;
        $display("FAIL stm_user step %0d: got %h want %h",
                 k, w_obs, exp_q[k]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_swp();
    build_model(32'hE1031092, 1'b1, 1'b0);
    i_instruction = 32'hE1031092;
    i_irq = 1'b1;
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      n_tests++;
      if (w_obs !== exp_q[k]) begin
        n_fail++;
        $display("FAIL swp step %0d: got %h want %h",
                 k, w_obs, exp_q[k]);
      end
      @(posedge clk); #1;
    end
    i_irq = 1'b0;
  endtask

  task automatic test_empty_list();
    build_model(32'hE8B00000, 1'b0, 1'b0);
    i_instruction = 32'hE8B00000;
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      n_tests++;
      if (w_obs !== exp_q[k]) begin
        n_fail++;
        $display("FAIL empty step %0d: got %h want %h",
                 k, w_obs, exp_q[k]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_passthrough();
    exp_t e;
    build_model(ADD_I, 1'b0, 1'b1);
    i_instruction = ADD_I;
    i_fiq = 1'b1;
    @(negedge clk);
    n_tests++;
    if (w_obs !== exp_q[0]) begin
      n_fail++;
      $display("FAIL pass: got %h want %h", w_obs, exp_q[0]);
    end
    @(posedge clk); #1;
    i_fiq = 1'b0;
    build_model(32'hE8B0000E, 1'b0, 1'b0);
    e = mk({3'b000, 32'hE8B0000E}, 0, 0, 0, 0, 0);
    e.v = 1'b0;
    i_instruction = 32'hE8B0000E;
    i_instruction_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (w_obs !== e) begin
      n_fail++;
      $display("FAIL pass_invalid: got %h want %h", w_obs, e);
    end
    @(posedge clk); #1;
    i_instruction_valid = 1'b1;
  endtask

  task automatic test_data_stall();
    build_model(32'hE8B0000E, 1'b0, 1'b0);
    i_instruction = 32'hE8B0000E;
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      n_tests++;
      if (w_obs !== exp_q[k]) begin
        n_fail++;
        $display("FAIL dstall step %0d: got %h want %h",
                 k, w_obs, exp_q[k]);
      end
      if (k == 2) begin
        i_data_stall = 1'b1;
        @(posedge clk); #1;
        i_data_stall = 1'b0;
        @(negedge clk);
        n_tests++;
        if (w_obs !== exp_q[k]) begin
          n_fail++;
          $display("FAIL dstall_repeat: got %h want %h",
                   w_obs, exp_q[k]);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_alu_clear();
    exp_t pass;
    build_model(ADD_I, 1'b0, 1'b0);
    pass = exp_q[0];
    build_model(32'hE8B0000E, 1'b0, 1'b0);
    i_instruction = 32'hE8B0000E;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin
        i_data_stall = 1'b1;
        i_clear_from_alu = 1'b1;
      end
      @(negedge clk);
      n_tests++;
      if (w_obs !== exp_q[k]) begin
        n_fail++;
        $display("FAIL aluclr step %0d: got %h want %h",
                 k, w_obs, exp_q[k]);
      end
      @(posedge clk); #1;
    end
    i_data_stall = 1'b0;
    @(negedge clk);
    n_tests++;
    if (w_obs !== exp_q[2]) begin
      n_fail++;
      $display("FAIL aluclr_prio: got %h want %h", w_obs, exp_q[2]);
    end
    @(posedge clk); #1;
    i_clear_from_alu = 1'b0;
    i_instruction = ADD_I;
    @(negedge clk);
    n_tests++;
    if (w_obs !== pass) begin
      n_fail++;
      $display("FAIL aluclr_idle: got %h want %h", w_obs, pass);
    end
    @(posedge clk); #1;
    i_instruction = 32'hE8B0000E;
    @(posedge clk); #1;
    i_clear_from_writeback = 1'b1;
    i_data_stall = 1'b1;
    @(posedge clk); #1;
    i_clear_from_writeback = 1'b0;
    i_data_stall = 1'b0;
    i_instruction = ADD_I;
    @(negedge clk);
    n_tests++;
    if (w_obs !== pass) begin
      n_fail++;
      $display("FAIL wbclr_idle: got %h want %h", w_obs, pass);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [31:0] ins;
    logic [3:0]  c;
    logic        iq, fq, hold;
    int          kind, which, k, cyc;
    for (int t = 0; t < 40; t++) begin
      c = 4'($urandom_range(0, 14));
      kind = $urandom_range(0, 5);
      if (kind <= 3)
        ins = {c, 3'b100, 5'($urandom), 4'($urandom),
               ($urandom_range(0, 6) == 0) ? 16'h0 : 16'($urandom)};
      else if (kind == 4)
        ins = {c, 5'b00010, 1'($urandom), 2'b00, 4'($urandom),
               4'($urandom), 8'h09, 4'($urandom)};
      else
        ins = {c, 3'b001, 25'($urandom)};
      iq = 1'($urandom);
      fq = 1'($urandom);
      build_model(ins, iq, fq);
      i_instruction = ins;
      i_irq = iq;
      i_fiq = fq;
      k = 0;
      cyc = 0;
      while (k < exp_q.size() && cyc < 200) begin
        hold = ($urandom_range(0, 3) == 0);
        which = $urandom_range(0, 2);
        i_data_stall = hold && which == 0;
        i_stall_from_shifter = hold && which == 1;
        i_issue_stall = hold && which == 2;
        @(negedge clk);
        n_tests++;
        if (w_obs !== exp_q[k]) begin
          n_fail++;
          $display("FAIL rand %h step %0d: got %h want %h",
                   ins, k, w_obs, exp_q[k]);
        end
        @(posedge clk); #1;
        if (!hold) k++;
        cyc++;
      end
      i_data_stall = 1'b0;
      i_stall_from_shifter = 1'b0;
      i_issue_stall = 1'b0;
      n_tests++;
      if (k < exp_q.size()) begin
        n_fail++;
        $display("FAIL rand_timeout: step %0d want %0d",
                 k, exp_q.size());
      end
    end
    i_irq = 1'b0;
    i_fiq = 1'b0;
  endtask

  initial begin
    i_reset = 1'b1;
    i_instruction = 32'h0;
    i_instruction_valid = 1'b0;
    i_irq = 1'b0;
    i_fiq = 1'b0;
    i_clear_from_writeback = 1'b0;
    i_data_stall = 1'b0;
    i_clear_from_alu = 1'b0;
    i_stall_from_shifter = 1'b0;
    i_issue_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_ldm_pc();
    test_stmdb();
    test_stm_user();
    test_swp();
    test_empty_list();
    test_passthrough();
    test_data_stall();
    test_alu_clear();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
